// File: rtl/tx_frame_encoder.sv
// 802.11a transmit framer: preamble, rate-1/2 coded SIGNAL field, then the scrambled
// and coded SERVICE/PSDU/TAIL/PAD DATA field, one coded bit per clock.
module tx_frame_encoder #(
  parameter logic [6:0] SEED = 7'b1011101
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [3:0]  Rate,
  input  logic [11:0] Length,
  input  logic [4:0]  num_pads,
  input  logic        x,
  output logic        Data_Req,
  output logic        y,
  output logic        Valid,
  output logic        Data_Phase,
  output logic        Busy,
  output logic        Done
);

  localparam int unsigned CNT_W     = 16;
  localparam int unsigned PRE_LEN   = 12;
  localparam int unsigned SIG_BITS  = 24;
  localparam int unsigned SVC_BITS  = 16;
  localparam int unsigned TAIL_BITS = 6;

  // S_LAST holds Busy for the cycle in which the final coded bit sits on y
  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SIG,
    S_DATA,
    S_LAST
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ab_q, ab_d;
  logic [5:0]         sr_q, sr_d;
  logic [6:0]         scr_q, scr_d;
  logic               u_q, u_d;
  logic [3:0]         rate_q, rate_d;
  logic [11:0]        len_q, len_d;
  logic [4:0]         pads_q, pads_d;
  logic               y_q, y_d;
  logic               valid_q, valid_d;
  logic               dphase_q, dphase_d;
  logic               done_q, done_d;

  logic [CNT_W-1:0]   psdu_end, tail_end, total_bits;
  logic [23:0]        sig_word;
  logic [4:0]         sig_idx;
  logic               sig_bit, sig_last, data_last;
  logic               in_psdu, in_tail;
  logic               data_in, scr_fb, data_bit;

  // Generator 133o taps: delays 0,2,3,5,6 (sr[i] holds the input delayed by i+1)
  function automatic logic enc_a(input logic u, input logic [5:0] sr);
    return u ^ sr[1] ^ sr[2] ^ sr[4] ^ sr[5];
  endfunction

  // Generator 171o taps: delays 0,1,2,3,6
  function automatic logic enc_b(input logic u, input logic [5:0] sr);
    return u ^ sr[0] ^ sr[1] ^ sr[2] ^ sr[5];
  endfunction

  // Frame section boundaries in uncoded-bit units
  assign psdu_end   = CNT_W'(SVC_BITS) + {1'b0, len_q, 3'b000};
  assign tail_end   = psdu_end + CNT_W'(TAIL_BITS);
  assign total_bits = tail_end + CNT_W'(pads_q);

  assign sig_word  = {rate_q, 1'b0, len_q, ^{rate_q, len_q}, 6'b000000};
  assign sig_idx   = 5'(SIG_BITS - 1) - cnt_q[4:0];
  assign sig_bit   = sig_word[sig_idx];
  assign sig_last  = (cnt_q == CNT_W'(SIG_BITS - 1));
  assign data_last = (cnt_q == CNT_W'(total_bits - CNT_W'(1)));

  assign in_psdu  = (cnt_q >= CNT_W'(SVC_BITS)) && (cnt_q < psdu_end);
  assign in_tail  = (cnt_q >= psdu_end) && (cnt_q < tail_end);
  assign data_in  = in_psdu ? x : 1'b0;
  assign scr_fb   = scr_q[6] ^ scr_q[3];
  assign data_bit = in_tail ? 1'b0 : (data_in ^ scr_fb);

  assign Data_Req   = (state_q == S_DATA) && !ab_q && in_psdu && !Reset;
  assign Busy       = (state_q != S_IDLE);
  assign y          = y_q;
  assign Valid      = valid_q;
  assign Data_Phase = dphase_q;
  assign Done       = done_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (Start) state_d = S_PRE;
      S_PRE:  if (cnt_q == CNT_W'(PRE_LEN - 1)) state_d = S_SIG;
      S_SIG:  if (ab_q && sig_last) state_d = S_DATA;
      S_DATA: if (ab_q && data_last) state_d = S_LAST;
      S_LAST: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values; each uncoded bit spends an A cycle then a B cycle
  always_comb begin
    cnt_d    = cnt_q;
    ab_d     = ab_q;
    sr_d     = sr_q;
    scr_d    = scr_q;
    u_d      = u_q;
    rate_d   = rate_q;
    len_d    = len_q;
    pads_d   = pads_q;
    y_d      = 1'b0;
    valid_d  = 1'b0;
    dphase_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        ab_d  = 1'b0;
        if (Start) begin
          rate_d = Rate;
          len_d  = Length;
          pads_d = num_pads;
        end
      end
      S_PRE: begin
        y_d     = 1'b1;
        valid_d = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(PRE_LEN - 1)) begin
          cnt_d = '0;
          ab_d  = 1'b0;
          sr_d  = '0;
        end
      end
      S_SIG: begin
        valid_d = 1'b1;
        if (!ab_q) begin
          y_d  = enc_a(sig_bit, sr_q);
          u_d  = sig_bit;
          ab_d = 1'b1;
        end else begin
          y_d   = enc_b(u_q, sr_q);
          sr_d  = {sr_q[4:0], u_q};
          ab_d  = 1'b0;
          cnt_d = cnt_q + CNT_W'(1);
          if (sig_last) begin
            cnt_d = '0;
            sr_d  = '0;
            scr_d = SEED;
          end
        end
      end
      S_DATA: begin
        valid_d  = 1'b1;
        dphase_d = 1'b1;
        if (!ab_q) begin
          y_d   = enc_a(data_bit, sr_q);
          u_d   = data_bit;
          scr_d = {scr_q[5:0], scr_fb};
          ab_d  = 1'b1;
        end else begin
          y_d   = enc_b(u_q, sr_q);
          sr_d  = {sr_q[4:0], u_q};
          ab_d  = 1'b0;
          cnt_d = data_last ? '0 : cnt_q + CNT_W'(1);
        end
      end
      S_LAST: begin
        done_d = 1'b1;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q    <= '0;
      ab_q     <= 1'b0;
      sr_q     <= '0;
      scr_q    <= SEED;
      u_q      <= 1'b0;
      rate_q   <= '0;
      len_q    <= '0;
      pads_q   <= '0;
      y_q      <= 1'b0;
      valid_q  <= 1'b0;
      dphase_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ab_q     <= ab_d;
      sr_q     <= sr_d;
      scr_q    <= scr_d;
      u_q      <= u_d;
      rate_q   <= rate_d;
      len_q    <= len_d;
      pads_q   <= pads_d;
      y_q      <= y_d;
      valid_q  <= valid_d;
      dphase_q <= dphase_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_tx_frame_encoder.sv
// Bench for tx_frame_encoder: reference framer/encoder fills a coded-bit scoreboard,
// DUT output is popped and compared while a side decoder recovers the uncoded bits.
module tb_tx_frame_encoder;

  localparam logic [6:0] SEED_T = 7'h7F;

  logic        Clk, Reset, Start, x;
  logic [3:0]  Rate;
  logic [11:0] Length;
  logic [4:0]  num_pads;
  logic        Data_Req, y, Valid, Data_Phase, Busy, Done;

  int n_checks = 0;
  int n_errors = 0;
  bit exp_q[$];
  bit psdu_q[$];

  tx_frame_encoder #(.SEED(SEED_T)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Rate(Rate), .Length(Length),
    .num_pads(num_pads), .x(x), .Data_Req(Data_Req), .y(y), .Valid(Valid),
    .Data_Phase(Data_Phase), .Busy(Busy), .Done(Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Reference encoder: window bit 6 is the current input, bit 0 the oldest
  function automatic void enc_push(input bit u, inout bit [5:0] h);
    bit [6:0] win;
    win = {u, h};
    exp_q.push_back(^(win & 7'b1011011));
    exp_q.push_back(^(win & 7'b1111001));
    h = win[6:1];
  endfunction

  task automatic run_frame(input logic [3:0] rate, input logic [11:0] len,
                           input logic [4:0] pads, input int rst_at, input bit chk_sig);
    int ln, n_unc, vcnt, dcnt, rcnt, last_req, done_at, ridx, rel, idx;
    bit [6:0] s;
    bit [5:0] h, dh;
    bit [23:0] sig, sig_dec;
    bit [15:0] svc_dec;
    bit d, o, u, tail_or, e;
    ln = int'(len);
    n_unc = 22 + 8 * ln + int'(pads);
    exp_q.delete();
    psdu_q.delete();
    for (int i = 0; i < 8 * ln; i++) psdu_q.push_back(1'($urandom_range(0, 1)));
    for (int i = 0; i < 12; i++) exp_q.push_back(1'b1);
    sig = {rate, 1'b0, len, ^{rate, len}, 6'b0};
    h = '0;
    for (int i = 23; i >= 0; i--) enc_push(sig[i], h);
    s = SEED_T;
    h = '0;
    for (int i = 0; i < n_unc; i++) begin
      d = (i >= 16 && i < 16 + 8 * ln) ? psdu_q[i - 16] : 1'b0;
      o = d ^ s[6] ^ s[3];
      s = {s[5:0], s[6] ^ s[3]};
      if (i >= 16 + 8 * ln && i < 22 + 8 * ln) o = 1'b0;
      enc_push(o, h);
    end

    Rate = rate; Length = len; num_pads = pads; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    chk("busy_after_start", Busy, 1);
    chk("valid_start_cycle", Valid, 0);
    vcnt = 0; dcnt = 0; rcnt = 0; last_req = -1; done_at = -1; ridx = 0;
    dh = '0; sig_dec = '0; svc_dec = '0; tail_or = 1'b0;
    for (int c = 1; c <= 80 + 2 * n_unc; c++) begin
      @(posedge Clk); #1;
      if (Done) begin
        done_at = c;
        chk("busy_in_done", Busy, 0);
        chk("valid_in_done", Valid, 0);
        break;
      end
      if (Data_Phase) dcnt++;
      if (Valid) begin
        vcnt++;
        if (exp_q.size() == 0) chk("valid_overrun", Valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("y_bit", y, e);
        end
        if (vcnt >= 13) begin
          if (vcnt == 13 || vcnt == 61) dh = '0;
          rel = (vcnt <= 60) ? vcnt - 13 : vcnt - 61;
          if (rel % 2 == 0) begin
            u = y ^ (^(dh & 6'b011011));
            dh = {u, dh[5:1]};
            idx = rel / 2;
            if (vcnt <= 60) sig_dec = {sig_dec[22:0], u};
            else begin
              if (idx < 16) svc_dec = {svc_dec[14:0], u};
              if (idx >= 16 + 8 * ln && idx < 22 + 8 * ln) tail_or |= u;
            end
          end
        end
      end
      if (Data_Req) begin
        rcnt++;
        if (last_req >= 0) chk("req_spacing", c - last_req, 2);
        last_req = c;
        if (ridx < psdu_q.size()) x = psdu_q[ridx];
        else chk("req_overrun", Data_Req, 0);
        ridx++;
      end
      if (c == 5 || c == 40) begin
        Start = 1'b1; Rate = ~rate; Length = len + 12'd1;
      end else begin
        Start = 1'b0; Rate = rate; Length = len;
      end
      if (c == rst_at) begin
        Start = 1'b0;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        chk("rst_y", y, 0);
        chk("rst_valid", Valid, 0);
        chk("rst_dphase", Data_Phase, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_req", Data_Req, 0);
        repeat (3) begin
          @(posedge Clk); #1;
          chk("no_done_after_rst", Done, 0);
        end
        return;
      end
    end
    chk("done_cycle", done_at, 61 + 2 * n_unc);
    chk("valid_count", vcnt, 60 + 2 * n_unc);
    chk("dphase_count", dcnt, 2 * n_unc);
    chk("req_count", rcnt, 8 * ln);
    chk("scoreboard_left", exp_q.size(), 0);
    chk("service_scrambled", svc_dec, 16'b0000111011110010);
    chk("tail_zero", tail_or, 0);
    if (chk_sig) chk("signal_decoded", sig_dec, 24'b1101_0_000001100100_0_000000);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Rate = '0; Length = '0; num_pads = '0; x = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_y", y, 0);
    chk("reset_valid", Valid, 0);
    chk("reset_dphase", Data_Phase, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    chk("reset_req", Data_Req, 0);
    Reset = 1'b0;
    repeat (20) begin
      @(posedge Clk); #1;
      chk("idle_y", y, 0);
      chk("idle_valid", Valid, 0);
      chk("idle_busy", Busy, 0);
      chk("idle_req", Data_Req, 0);
    end
    run_frame(4'b1101, 12'd0, 5'd0, -1, 1'b0);
    run_frame(4'b1101, 12'd100, 5'd3, -1, 1'b1);
    run_frame(4'b0101, 12'd2, 5'd5, -1, 1'b0);
    run_frame(4'b1011, 12'd3, 5'd1, 30, 1'b0);
    run_frame(4'b1111, 12'd1, 5'd7, -1, 1'b0);
    run_frame(4'b0001, 12'd2, 5'd31, -1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
